rpsc_fault_reporter: RTL and testbench
======================================

Name: rpsc_fault_reporter

Overview:
- Reads the latched fault-lamp (LA) outputs of an RPSC fault card (up to 8 fault flip-flops, FF9..FF16 style) and transmits them to the remote status panel.
- Uses a fixed-format asynchronous serial frame.
- Tracks the first-out fault so the panel knows which trip occurred first.
- Sits between the fault card LA outputs and the panel link, on the card clock.

Parameters:
- N_FAULTS, 8, number of LA inputs used (1..8); unused data bits are transmitted as 0.
- BAUD_DIV, 16, clock cycles per serial bit (>=2).
- REFRESH_CYCLES, 100000, clock cycles between frame starts when no change occurs (>= frame length).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- la_in  input  N_FAULTS  latched fault lamp levels from the fault card; asynchronous to clk
- force_send  input  1  single-cycle request to send a frame immediately
- tx  output  1  serial line; idles high
- busy  output  1  high while a frame is in flight (start bit through stop bit)
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit
- first_fault  output  4  bit 3 = valid, bits 2:0 = index of first-out fault

Behaviour:
- Reset (async, active-high):
  - tx=1, busy=0, frame_done=0, first_fault=0.
  - Synchronizers, snapshot and pending are cleared; the refresh counter is cleared; FSM goes to IDLE.
  - Reset asserted mid-frame aborts the frame immediately (tx=1 asynchronously).
- Input sync: each la_in bit passes through a 2-flop synchronizer; all logic uses the synced vector S.
- First-out tracking:
  - If first_fault.valid=0 and S has any bit set, latch valid=1 and the index of the lowest set bit. Simultaneous rises resolve to the lowest index.
  - Hold while valid=1.
  - Clear to 0 when S==0 for one cycle.
  - Updates regardless of FSM state.
- Trigger conditions, evaluated every cycle: S != last transmitted snapshot; OR force_send; OR refresh counter == REFRESH_CYCLES-1.
  - A trigger arriving in IDLE starts a frame on the next edge.
  - A trigger arriving while busy sets pending. After STOP, go directly to START (no idle bit) if pending or S != snapshot. Pending clears at that frame start.
- Refresh counter: reset to 0 at every frame start; otherwise increments, saturating at REFRESH_CYCLES-1.
- Frame start: capture snapshot D = S zero-extended to 8 bits, F = first_fault, P = even parity over {F,D} (12 bits, so the 12 bits plus P have even ones).
- Frame format, 15 bits, each held exactly BAUD_DIV cycles:
  - start bit 0
  - D[0]..D[7], LSB first
  - F[0]..F[3]
  - P
  - stop bit 1
- FSM states: IDLE -> START -> DATA (8 bits) -> FO (4 bits) -> PARITY -> STOP -> IDLE or START.
  - A baud counter counts 0..BAUD_DIV-1 within each bit.
  - A bit index counts within DATA and FO.
- busy=1 from the first START cycle through the last STOP cycle.
- frame_done is asserted on the final cycle of STOP.
- Latency: a la_in change is visible in S after 2 edges; tx falls on the 3rd edge after the change when IDLE. force_send in IDLE makes tx fall on the next edge.
- Frame length: exactly 15*BAUD_DIV cycles. Frame contents never change after capture, even if la_in changes mid-frame.

Test Plan:
- Reset, then la_in=0, BAUD_DIV=4 -> tx stays 1 and busy=0 until a refresh at cycle REFRESH_CYCLES-1; the frame then carries D=0x00, F=0x0, P=0 and lasts 60 cycles with one frame_done pulse.
- la_in 0x00->0x20 -> tx low on the 3rd edge. Frame D=0x20, F=0xD (valid, index 5), P=0 (4 ones), stop=1. first_fault holds 0xD afterward.
- la_in 0x00->0x0A in one cycle -> first_fault=0x9 (valid, index 1, lowest set bit wins). A later 0x0A->0x8A leaves first_fault at 0x9 and sends a second frame with D=0x8A.
- During a frame, change la_in 0x01->0x03 at bit 3 -> the current frame still sends D=0x01. A second frame starts on the cycle after the stop bit (busy stays high) with D=0x03.
- Mid-frame async reset -> tx=1 immediately, busy=0, first_fault=0. After release with la_in=0x04, a fresh frame sends D=0x04, F=0xA.
- force_send pulse while IDLE and S unchanged -> frame starts the next edge. A second force_send during that frame produces exactly one back-to-back frame. The refresh counter restarts at each frame start.

Source files
------------

// File: rtl/rpsc_fault_reporter.sv
// Serial reporter for RPSC fault-card lamp outputs: it synchronises the lamps, tracks the first-out fault,
// and sends fixed 15-bit frames to the remote panel on change, on request, or on periodic refresh.
module rpsc_fault_reporter #(
    parameter int N_FAULTS       = 8,
    parameter int BAUD_DIV       = 16,
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FAULTS-1:0] la_in,
    input  logic                force_send,
    output logic                tx,
    output logic                busy,
    output logic                frame_done,
    output logic [3:0]          first_fault
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int RW = $clog2(REFRESH_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_FO,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t              state_q;
    logic [N_FAULTS-1:0] sync1_q, s_q;
    logic [3:0]          ff_q, ff_d;
    logic [7:0]          snap_d_q;
    logic [3:0]          snap_f_q;
    logic                snap_p_q;
    logic                pending_q;
    logic [RW-1:0]       refresh_q;
    logic [BW-1:0]       baud_q;
    logic [2:0]          bit_q;
    logic                tx_q, busy_q, done_q;

    logic [7:0] s8;
    logic [2:0] low_idx;
    logic       baud_last, trigger, go, start_frame;

    always_comb begin
        s8 = '0;
        s8[N_FAULTS-1:0] = s_q;
        low_idx = '0;
        for (int i = N_FAULTS - 1; i >= 0; i--) begin
            if (s_q[i]) low_idx = 3'(i);
        end
        ff_d = ff_q;
        if (s_q == '0)
            ff_d = '0;
        else if (!ff_q[3])
            ff_d = {1'b1, low_idx};
        baud_last   = (baud_q == BW'(BAUD_DIV - 1));
        trigger     = (s8 != snap_d_q) || force_send || (refresh_q == RW'(REFRESH_CYCLES - 1));
        go          = trigger || pending_q;
        start_frame = go && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_last));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sync1_q   <= '0;
            s_q       <= '0;
            ff_q      <= '0;
            snap_d_q  <= '0;
            snap_f_q  <= '0;
            snap_p_q  <= 1'b0;
            pending_q <= 1'b0;
            refresh_q <= '0;
            baud_q    <= '0;
            bit_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sync1_q <= la_in;
            s_q     <= sync1_q;
            ff_q    <= ff_d;
            done_q  <= 1'b0;

            if (start_frame)
                refresh_q <= '0;
            else if (refresh_q != RW'(REFRESH_CYCLES - 1))
                refresh_q <= refresh_q + 1'b1;

            if (start_frame)
                pending_q <= 1'b0;
            else if (trigger && (state_q != ST_IDLE))
                pending_q <= 1'b1;

            // The captured first-out uses this cycle's update so a fresh trip is reported in its own frame.
            if (start_frame) begin
                state_q  <= ST_START;
                baud_q   <= '0;
                bit_q    <= '0;
                tx_q     <= 1'b0;
                busy_q   <= 1'b1;
                snap_d_q <= s8;
                snap_f_q <= ff_d;
                snap_p_q <= ^{ff_d, s8};
            end else begin
                if (state_q != ST_IDLE)
                    baud_q <= baud_last ? '0 : baud_q + 1'b1;
                case (state_q)
                    ST_IDLE: ;
                    ST_START:
                        if (baud_last) begin
                            state_q <= ST_DATA;
                            tx_q    <= snap_d_q[0];
                        end
                    ST_DATA:
                        if (baud_last) begin
                            if (bit_q == 3'd7) begin
                                state_q <= ST_FO;
                                bit_q   <= '0;
                                tx_q    <= snap_f_q[0];
                            end else begin
                                bit_q <= bit_q + 3'd1;
                                tx_q  <= snap_d_q[bit_q + 3'd1];
                            end
                        end
                    ST_FO:
                        if (baud_last) begin
                            if (bit_q == 3'd3) begin
                                state_q <= ST_PARITY;
                                bit_q   <= '0;
                                tx_q    <= snap_p_q;
                            end else begin
                                bit_q <= bit_q + 3'd1;
                                tx_q  <= snap_f_q[bit_q[1:0] + 2'd1];
                            end
                        end
                    ST_PARITY:
                        if (baud_last) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end
                    ST_STOP: begin
                        if (baud_q == BW'(BAUD_DIV - 2)) done_q <= 1'b1;
                        if (baud_last) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign first_fault = ff_q;

endmodule

// File: tb/tb_rpsc_fault_reporter.sv
// Randomised scenario bench for rpsc_fault_reporter: frames are decoded off tx and compared
// against frames built from the lamp values and first-out rule.
module tb_rpsc_fault_reporter;

    localparam int N = 8;
    localparam int B = 4;
    localparam int R = 200;
    localparam int L = 15 * B;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] la_in;
    logic         force_send;
    logic         tx, busy, frame_done;
    logic [3:0]   first_fault;

    int total = 0;
    int bad   = 0;

    rpsc_fault_reporter #(.N_FAULTS(N), .BAUD_DIV(B), .REFRESH_CYCLES(R)) dut (
        .clk(clk), .reset(reset), .la_in(la_in), .force_send(force_send),
        .tx(tx), .busy(busy), .frame_done(frame_done), .first_fault(first_fault)
    );

    always #5 clk = ~clk;

    // first-out from an all-clear start: valid plus lowest lit lamp
    function automatic logic [3:0] ff_model(input logic [7:0] v);
        if (v == 8'h00) return 4'h0;
        for (int i = 0; i < 8; i++)
            if (v[i]) return {1'b1, 3'(i)};
        return 4'h0;
    endfunction

    function automatic logic [14:0] frame_model(input logic [7:0] d, input logic [3:0] f);
        logic [14:0] b;
        int ones;
        ones = 0;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin b[1+i] = d[i]; ones += int'(d[i]); end
        for (int i = 0; i < 4; i++) begin b[9+i] = f[i]; ones += int'(f[i]); end
        b[13] = ((ones % 2) == 1);
        b[14] = 1'b1;
        return b;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; force_send = 1'b0; la_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_fall(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < limit);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Called at the negedge of the first cycle of a frame; ends at the negedge of its last cycle.
    task automatic recv(input string name, input logic [7:0] d, input logic [3:0] f,
                        input int chg_at, input logic [7:0] chg_val, input int force_at);
        logic [14:0] exp, got;
        int wrong, notbusy, dones, done_pos;
        exp = frame_model(d, f);
        got = '0; wrong = 0; notbusy = 0; dones = 0; done_pos = -1;
        for (int j = 0; j < L; j++) begin
            if (j > 0) @(negedge clk);
            if (tx !== exp[j / B]) wrong++;
            if ((j % B) == B / 2) got[j / B] = tx;
            if (busy !== 1'b1) notbusy++;
            if (frame_done === 1'b1) begin dones++; done_pos = j; end
            force_send = (j == force_at);
            if (j == chg_at) la_in = chg_val;
        end
        force_send = 1'b0;
        total++;
        if (got !== exp || wrong != 0) begin
            bad++;
            $display("FAIL %s_bits got=%h want=%h badcycles=%0d", name, got, exp, wrong);
        end
        check_int({name, "_busy_low_cycles"}, notbusy, 0);
        check_int({name, "_done_pulses"}, dones, 1);
        check_int({name, "_done_pos"}, done_pos, L - 1);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || first_fault !== 4'h0) begin
            bad++;
            $display("FAIL reset_state got tx=%b busy=%b done=%b ff=%h want 1 0 0 0",
                     tx, busy, frame_done, first_fault);
        end
    endtask

    task automatic test_refresh();
        int n;
        do_reset();
        wait_fall(R + 20, n);
        check_int("refresh_latency", n, R);
        recv("refresh", 8'h00, 4'h0, -1, 8'h00, -1);
        @(negedge clk);
        check_int("refresh_idle_after", int'({busy, tx}), 1);
    endtask

    task automatic test_lamp();
        int n, idx;
        logic [7:0] v;
        for (int it = 0; it < 3; it++) begin
            idx = (it == 0) ? 5 : int'($urandom_range(0, N - 1));
            v = 8'(1 << idx);
            do_reset();
            la_in = v;
            wait_fall(10, n);
            check_int("lamp_latency", n, 3);
            recv("lamp", v, ff_model(v), -1, 8'h00, -1);
            @(negedge clk);
            check_int("lamp_first_fault", int'(first_fault), int'(ff_model(v)));
            check_int("lamp_busy_after", int'(busy), 0);
        end
    endtask

    task automatic test_multi();
        int n, a, b, c;
        logic [7:0] v, v2;
        for (int it = 0; it < 2; it++) begin
            a = (it == 0) ? 1 : int'($urandom_range(0, 6));
            b = (it == 0) ? 3 : int'($urandom_range(a + 1, 7));
            v = 8'((1 << a) | (1 << b));
            c = (it == 0) ? 7 : int'($urandom_range(0, 7));
            while (v[c]) c = int'($urandom_range(0, 7));
            v2 = v | 8'(1 << c);
            do_reset();
            la_in = v;
            wait_fall(10, n);
            check_int("multi_latency", n, 3);
            recv("multi1", v, ff_model(v), -1, 8'h00, -1);
            @(negedge clk);
            check_int("multi_first_fault", int'(first_fault), int'(ff_model(v)));
            la_in = v2;
            wait_fall(10, n);
            check_int("multi2_latency", n, 3);
            recv("multi2", v2, ff_model(v), -1, 8'h00, -1);
            @(negedge clk);
            check_int("multi_ff_held", int'(first_fault), int'(ff_model(v)));
        end
    endtask

    task automatic test_back_to_back();
        int n, a, c;
        logic [7:0] v, v2;
        for (int it = 0; it < 2; it++) begin
            a = (it == 0) ? 0 : int'($urandom_range(0, 7));
            c = (it == 0) ? 1 : int'($urandom_range(0, 7));
            while (c == a) c = int'($urandom_range(0, 7));
            v  = 8'(1 << a);
            v2 = v | 8'(1 << c);
            do_reset();
            la_in = v;
            wait_fall(10, n);
            check_int("b2b_latency", n, 3);
            recv("b2b1", v, ff_model(v), 3 * B, v2, -1);
            @(negedge clk);
            check_int("b2b_restart", int'({tx, busy}), 1);
            recv("b2b2", v2, ff_model(v), -1, 8'h00, -1);
            @(negedge clk);
            check_int("b2b_busy_after", int'(busy), 0);
        end
    endtask

    task automatic test_async_reset();
        int n, a;
        logic [7:0] v, w;
        for (int it = 0; it < 2; it++) begin
            a = int'($urandom_range(0, 7));
            v = 8'(1 << a);
            w = (it == 0) ? 8'h04 : 8'($urandom_range(1, 255));
            do_reset();
            la_in = v;
            wait_fall(10, n);
            repeat ($urandom_range(5, 40)) @(negedge clk);
            #1 reset = 1'b1;
            #1;
            total++;
            if (tx !== 1'b1 || busy !== 1'b0 || first_fault !== 4'h0) begin
                bad++;
                $display("FAIL async_reset got tx=%b busy=%b ff=%h want 1 0 0", tx, busy, first_fault);
            end
            @(negedge clk);
            la_in = w;
            reset = 1'b0;
            wait_fall(10, n);
            check_int("post_reset_latency", n, 3);
            recv("post_reset", w, ff_model(w), -1, 8'h00, -1);
        end
    endtask

    task automatic test_force();
        int n, fa;
        do_reset();
        repeat (5) @(negedge clk);
        force_send = 1'b1;
        @(negedge clk);
        force_send = 1'b0;
        check_int("force_latency_tx", int'(tx), 0);
        fa = int'($urandom_range(2, L - 3));
        recv("force1", 8'h00, 4'h0, -1, 8'h00, fa);
        @(negedge clk);
        check_int("force_b2b_restart", int'({tx, busy}), 1);
        recv("force2", 8'h00, 4'h0, -1, 8'h00, -1);
        @(negedge clk);
        check_int("force_single_b2b", int'({tx, busy}), 2);
        wait_fall(R + 20, n);
        check_int("force_refresh_restart", n, R - L);
    endtask

    initial begin
        reset = 1'b1;
        force_send = 1'b0;
        la_in = '0;
        test_reset();
        test_refresh();
        test_lamp();
        test_multi();
        test_back_to_back();
        test_async_reset();
        test_force();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
